// File: rtl/nv_nvdla_pdp_cal1d_info_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nv_nvdla_pdp_cal1d_info_fifo_ctrl
// Brief    : Control stage for the PDP cal1d info flop-RAM: write strobes,
//            read sequencing and a registered valid/ready output stage.
// Revision : 1.0
// ============================================================================
module nv_nvdla_pdp_cal1d_info_fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_pvld,
  output logic             wr_prdy,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_pvld,
  input  logic             rd_prdy,
  output logic [WIDTH-1:0] rd_pd,
  output logic             ram_we,
  output logic [AW-1:0]    ram_wa,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW:0]      ram_ra,
  input  logic [WIDTH-1:0] ram_dout,
  output logic [AW:0]      ram_count
);

  localparam logic [AW:0] c_full      = DEPTH[AW:0];
  localparam logic [AW:0] c_bypass_ra = DEPTH[AW:0];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             rd_pvld_q, rd_pvld_d;
  logic [WIDTH-1:0] rd_pd_q, rd_pd_d;

  logic w_out_ld;
  logic w_wr_prdy;
  logic w_wr_acc;
  logic w_ram_rd;
  logic w_bypass;
  logic w_ram_wr;

  // Ready comes from registered count only, so a same-cycle pop at full
  // does not open the write port.
  always_comb begin
    w_out_ld  = !rd_pvld_q | rd_prdy;
    w_wr_prdy = (count_q != c_full);
    w_wr_acc  = wr_pvld & w_wr_prdy;
    w_ram_rd  = w_out_ld & (count_q != '0);
    w_bypass  = w_out_ld & (count_q == '0) & w_wr_acc;
    w_ram_wr  = w_wr_acc & !w_bypass;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_pvld_d = rd_pvld_q;
    rd_pd_d   = rd_pd_q;
    count_d   = count_q + {{AW{1'b0}}, w_ram_wr} - {{AW{1'b0}}, w_ram_rd};
    if (w_ram_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_out_ld) begin
      rd_pvld_d = w_ram_rd | w_bypass;
      if (w_ram_rd | w_bypass) begin
        rd_pd_d = ram_dout;
      end
    end
    if (w_ram_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_pvld_q <= 1'b0;
      rd_pd_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_pvld_q <= rd_pvld_d;
      rd_pd_q   <= rd_pd_d;
    end
  end

  // The bypass address makes the RAM return di, so both read paths load dout.
  assign wr_prdy   = w_wr_prdy;
  assign rd_pvld   = rd_pvld_q;
  assign rd_pd     = rd_pd_q;
  assign ram_we    = w_ram_wr;
  assign ram_wa    = wr_ptr_q;
  assign ram_di    = wr_pd;
  assign ram_ra    = w_bypass ? c_bypass_ra : {1'b0, rd_ptr_q};
  assign ram_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_pdp_cal1d_info_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nv_nvdla_pdp_cal1d_info_fifo_ctrl
// Brief    : Randomized bench with a 9-word queue model of the whole FIFO.
// Revision : 1.0
// ============================================================================
module tb_nv_nvdla_pdp_cal1d_info_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_pvld;
  logic        wr_prdy;
  logic [11:0] wr_pd;
  logic        rd_pvld;
  logic        rd_prdy;
  logic [11:0] rd_pd;
  logic        ram_we;
  logic [2:0]  ram_wa;
  logic [11:0] ram_di;
  logic [3:0]  ram_ra;
  logic [11:0] ram_dout;
  logic [3:0]  ram_count;

  int total = 0;
  int bad   = 0;

  logic [11:0] q[$];
  logic [11:0] mem[8];
  bit          stall_prev = 1'b0;
  logic [11:0] prev_pd;

  always #5 clk = ~clk;

  nv_nvdla_pdp_cal1d_info_fifo_ctrl #(.DEPTH(8), .WIDTH(12), .AW(3)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .wr_pvld   (wr_pvld),
    .wr_prdy   (wr_prdy),
    .wr_pd     (wr_pd),
    .rd_pvld   (rd_pvld),
    .rd_prdy   (rd_prdy),
    .rd_pd     (rd_pd),
    .ram_we    (ram_we),
    .ram_wa    (ram_wa),
    .ram_di    (ram_di),
    .ram_ra    (ram_ra),
    .ram_dout  (ram_dout),
    .ram_count (ram_count)
  );

  // Flop-RAM stand-in: 8 entries, address 8 returns di.
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
  end
  assign ram_dout = (ram_ra == 4'd8) ? ram_di : mem[ram_ra[2:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: check outputs against the queue model, then advance both.
  task automatic cycle(output bit acc);
    int occ;
    bit m_prdy, m_acc, m_pop, m_byp;
    #1;
    occ    = q.size();
    m_prdy = (occ != 9);
    m_acc  = wr_pvld && m_prdy;
    m_pop  = (occ > 0) && rd_prdy;
    m_byp  = m_acc && (occ == 0 || (occ == 1 && rd_prdy));
    check("rd_pvld", {31'd0, rd_pvld}, {31'd0, occ > 0});
    if (occ > 0) check("rd_pd", {20'd0, rd_pd}, {20'd0, q[0]});
    check("ram_count", {28'd0, ram_count}, (occ > 0) ? occ - 1 : 0);
    check("wr_prdy", {31'd0, wr_prdy}, {31'd0, m_prdy});
    check("ram_we", {31'd0, ram_we}, {31'd0, m_acc && !m_byp});
    if (m_byp) check("ram_ra_byp", {28'd0, ram_ra}, 32'd8);
    check("ram_di", {20'd0, ram_di}, {20'd0, wr_pd});
    if (stall_prev) check("stall_pd", {20'd0, rd_pd}, {20'd0, prev_pd});
    stall_prev = rd_pvld && !rd_prdy;
    prev_pd    = rd_pd;
    @(posedge clk);
    if (m_pop) void'(q.pop_front());
    if (m_acc) q.push_back(wr_pd);
    #1;
    acc = m_acc;
  endtask

  task automatic drain();
    bit a;
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    for (int i = 0; i < 12; i++) cycle(a);
    check("drained", {28'd0, ram_count}, 32'd0);
  endtask

  initial begin
    bit a;
    int n;
    rst = 1'b1; wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b0;
    #12;
    check("rst_pvld", {31'd0, rd_pvld}, 32'd0);
    check("rst_pd", {20'd0, rd_pd}, 32'd0);
    check("rst_cnt", {28'd0, ram_count}, 32'd0);
    check("rst_prdy", {31'd0, wr_prdy}, 32'd1);
    check("rst_we", {31'd0, ram_we}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single bypass write
    wr_pvld = 1'b1; wr_pd = 12'hABC; rd_prdy = 1'b1;
    cycle(a);
    wr_pvld = 1'b0;
    check("t1_pvld", {31'd0, rd_pvld}, 32'd1);
    check("t1_pd", {20'd0, rd_pd}, 32'hABC);
    cycle(a);
    check("t1_pvld_off", {31'd0, rd_pvld}, 32'd0);

    // Fill to 9 with output stalled, 10th held off
    rd_prdy = 1'b0; n = 1;
    for (int i = 0; i < 10; i++) begin
      wr_pvld = 1'b1; wr_pd = n[11:0];
      cycle(a);
      if (a) n++;
    end
    check("t2_accepts", n - 1, 32'd9);
    check("t2_cnt", {28'd0, ram_count}, 32'd8);
    check("t2_prdy", {31'd0, wr_prdy}, 32'd0);
    check("t2_head", {20'd0, rd_pd}, 32'h001);

    // Full with simultaneous pop and write attempt
    wr_pvld = 1'b1; wr_pd = 12'h00A; rd_prdy = 1'b1;
    cycle(a);
    check("t4_noacc", {31'd0, a}, 32'd0);
    check("t4_cnt", {28'd0, ram_count}, 32'd7);
    check("t4_prdy", {31'd0, wr_prdy}, 32'd1);
    drain();

    // Streaming 20 words through
    rd_prdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_pvld = 1'b1; wr_pd = 12'h100 + i[11:0];
      cycle(a);
      check("t3_acc", {31'd0, a}, 32'd1);
      check("t3_cnt_le1", {31'd0, ram_count <= 4'd1}, 32'd1);
    end
    drain();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      wr_pvld = 1'($urandom_range(0, 1));
      wr_pd   = 12'($urandom);
      rd_prdy = (i < 250) ? (i % 2 == 0) : 1'($urandom_range(0, 1));
      cycle(a);
    end
    drain();

    // Async reset with 5 words in RAM
    rd_prdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_pvld = 1'b1; wr_pd = 12'h300 + i[11:0];
      cycle(a);
    end
    wr_pvld = 1'b0;
    check("t6_pre_cnt", {28'd0, ram_count}, 32'd5);
    #2 rst = 1'b1;
    #1;
    check("t6_pvld", {31'd0, rd_pvld}, 32'd0);
    check("t6_cnt", {28'd0, ram_count}, 32'd0);
    check("t6_prdy", {31'd0, wr_prdy}, 32'd1);
    q.delete();
    stall_prev = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    wr_pvld = 1'b1; wr_pd = 12'h5A5; rd_prdy = 1'b1;
    cycle(a);
    wr_pvld = 1'b0;
    check("t6_first_pvld", {31'd0, rd_pvld}, 32'd1);
    check("t6_first_pd", {20'd0, rd_pd}, 32'h5A5);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
